// File: rtl/plru_victim_select_if.sv
// -----------------------------------------------------------------------------
// plru_victim_select_if
// Purpose : Bundles the lookup, touch and victim-result signals exchanged
//           between the cache controller and the pseudo-LRU victim selector.
// Ports   : (interface signals)
//   lookup_valid / lookup_set / way_valid  - victim request from the cache FSM
//   touch_valid  / touch_set  / touch_way  - hit/fill report from the datapath
//   victim_valid / victim_way              - registered victim result
// Modports: master = cache side (drives requests, receives victim)
//           slave  = PLRU tracker side
// -----------------------------------------------------------------------------
interface plru_victim_select_if #(
  parameter int NUM_SETS = 16
);
  localparam int SET_W = $clog2(NUM_SETS);

  logic             lookup_valid;
  logic [SET_W-1:0] lookup_set;
  logic [3:0]       way_valid;
  logic             touch_valid;
  logic [SET_W-1:0] touch_set;
  logic [1:0]       touch_way;
  logic             victim_valid;
  logic [1:0]       victim_way;

  modport master (
    output lookup_valid, lookup_set, way_valid,
    output touch_valid, touch_set, touch_way,
    input  victim_valid, victim_way
  );

  modport slave (
    input  lookup_valid, lookup_set, way_valid,
    input  touch_valid, touch_set, touch_way,
    output victim_valid, victim_way
  );
endinterface

// File: rtl/plru_victim_select.sv
// -----------------------------------------------------------------------------
// plru_victim_select
// Purpose : Per-set 3-bit tree pseudo-LRU tracker for a 4-way set-associative
//           cache. A lookup returns a registered victim way one cycle later;
//           hits/fills are reported as touches and update the set's tree.
// Ports   :
//   clk    in  core clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    plru_victim_select_if.slave
//            lookup_valid/lookup_set/way_valid  victim request
//            touch_valid/touch_set/touch_way    access report
//            victim_valid/victim_way            one-cycle result pulse + way
// Config  : PLRU_BYPASS_EN - when defined, a touch to the set being looked up
//           in the same cycle is forwarded into the victim decode. When
//           undefined, the lookup sees the registered (pre-touch) tree bits.
// -----------------------------------------------------------------------------
module plru_victim_select #(
  parameter int NUM_SETS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  plru_victim_select_if.slave  bus
);
  localparam int SET_W = $clog2(NUM_SETS);

  // Tree bits are {b2,b1,b0}. b0 picks the pair (0: ways 0/1, 1: ways 2/3),
  // b1 picks within the left pair, b2 within the right pair.
  function automatic logic [2:0] touch_update(input logic [2:0] tree,
                                              input logic [1:0] way);
    logic [2:0] t;
    t = tree;
    unique case (way)
      2'd0: begin t[0] = 1'b1; t[1] = 1'b1; end
      2'd1: begin t[0] = 1'b1; t[1] = 1'b0; end
      2'd2: begin t[0] = 1'b0; t[2] = 1'b1; end
      default: begin t[0] = 1'b0; t[2] = 1'b0; end
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tree_decode(input logic [2:0] tree);
    logic [1:0] w;
    if (!tree[0]) w = tree[1] ? 2'd1 : 2'd0;
    else          w = tree[2] ? 2'd3 : 2'd2;
    return w;
  endfunction

  // Flat read view of every set's tree for the lookup mux.
  logic [2:0] tree_all [NUM_SETS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
      logic [2:0] tree_d;
      logic [2:0] tree_q;

      always_comb begin
        tree_d = tree_q;
        if (bus.touch_valid && (bus.touch_set == SET_W'(gi)))
          tree_d = touch_update(tree_q, bus.touch_way);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tree_q <= 3'b000;
        else        tree_q <= tree_d;
      end

      assign tree_all[gi] = tree_q;
    end
  endgenerate

  // Victim computation for the current lookup.
  logic [2:0] lookup_tree;
  logic [1:0] victim_calc;
  logic       victim_valid_d, victim_valid_q;
  logic [1:0] victim_way_d,   victim_way_q;

  always_comb begin
    lookup_tree = tree_all[bus.lookup_set];
`ifdef PLRU_BYPASS_EN
    // Forward a same-cycle touch so the lookup sees the post-touch tree.
    if (bus.touch_valid && (bus.touch_set == bus.lookup_set))
      lookup_tree = touch_update(lookup_tree, bus.touch_way);
`endif

    // An empty way always wins over the tree choice, lowest index first.
    if      (!bus.way_valid[0]) victim_calc = 2'd0;
    else if (!bus.way_valid[1]) victim_calc = 2'd1;
    else if (!bus.way_valid[2]) victim_calc = 2'd2;
    else if (!bus.way_valid[3]) victim_calc = 2'd3;
    else                        victim_calc = tree_decode(lookup_tree);
  end

  always_comb begin
    victim_valid_d = bus.lookup_valid;
    victim_way_d   = victim_way_q;
    if (bus.lookup_valid) victim_way_d = victim_calc;
  end

  // Async reset clears the pulse, so a lookup in flight at reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= 2'b00;
    end else begin
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;

endmodule

// File: tb/tb_plru_victim_select.sv
// -----------------------------------------------------------------------------
// tb_plru_victim_select
// Directed self-checking bench for plru_victim_select. Inputs are driven on
// the falling edge and outputs sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_plru_victim_select;
  localparam int NUM_SETS = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  plru_victim_select_if #(.NUM_SETS(NUM_SETS)) bus ();

  plru_victim_select #(.NUM_SETS(NUM_SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.lookup_valid = 1'b0;
    bus.lookup_set   = '0;
    bus.way_valid    = 4'hF;
    bus.touch_valid  = 1'b0;
    bus.touch_set    = '0;
    bus.touch_way    = 2'd0;
  endtask

  // Issue a lookup at the current falling edge; check the result one cycle later.
  task automatic lookup(input string tag, input logic [3:0] set,
                        input logic [3:0] wv, input logic [1:0] exp_way);
    bus.lookup_valid = 1'b1;
    bus.lookup_set   = set;
    bus.way_valid    = wv;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    bus.way_valid    = 4'hF;
    chk({tag, "_vld"}, {3'b0, bus.victim_valid}, 4'h1);
    chk({tag, "_way"}, {2'b0, bus.victim_way}, {2'b0, exp_way});
    $display("lookup %s set=%0d way_valid=%b -> valid=%0b way=%0d (exp %0d)",
             tag, set, wv, bus.victim_valid, bus.victim_way, exp_way);
  endtask

  task automatic touch(input logic [3:0] set, input logic [1:0] way);
    bus.touch_valid = 1'b1;
    bus.touch_set   = set;
    bus.touch_way   = way;
    @(negedge clk);
    bus.touch_valid = 1'b0;
    $display("touch set=%0d way=%0d", set, way);
  endtask

  logic [1:0] exp_same;
  logic [1:0] held_way;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", {3'b0, bus.victim_valid}, 4'h0);
    chk("rst_way", {2'b0, bus.victim_way}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_vld", {3'b0, bus.victim_valid}, 4'h0);

    // First lookup from reset.
    lookup("s0_init", 4'd0, 4'hF, 2'd0);

    // Result holds while no pulse.
    held_way = 2'd0;
    lookup("s5_1011", 4'd5, 4'b1011, 2'd2);
    @(negedge clk);
    chk("hold_vld", {3'b0, bus.victim_valid}, 4'h0);
    chk("hold_way", {2'b0, bus.victim_way}, 4'h2);

    // Invalid-way priority, back-to-back lookups.
    lookup("s5_0000", 4'd5, 4'b0000, 2'd0);
    lookup("s5_1110", 4'd5, 4'b1110, 2'd0);
    lookup("s5_1101", 4'd5, 4'b1101, 2'd1);
    lookup("s5_0111", 4'd5, 4'b0111, 2'd3);

    // Set 3: touch all ways in order -> tree returns to 000.
    touch(4'd3, 2'd0);
    touch(4'd3, 2'd1);
    touch(4'd3, 2'd2);
    touch(4'd3, 2'd3);
    lookup("s3_all", 4'd3, 4'hF, 2'd0);
    touch(4'd3, 2'd0);
    lookup("s3_t0", 4'd3, 4'hF, 2'd2);
    // Invalid priority beats the tree on a non-reset tree.
    lookup("s3_inv", 4'd3, 4'b1101, 2'd1);

    // Set 4: way2 then way0; b2 from the first touch must survive the second.
    touch(4'd4, 2'd2);
    lookup("s4_t2", 4'd4, 4'hF, 2'd0);
    touch(4'd4, 2'd0);
    lookup("s4_t0", 4'd4, 4'hF, 2'd3);
    touch(4'd4, 2'd3);
    lookup("s4_t3", 4'd4, 4'hF, 2'd1);

    // Same-cycle touch + lookup on set 7.
`ifdef PLRU_BYPASS_EN
    exp_same = 2'd2;
`else
    exp_same = 2'd0;
`endif
    bus.touch_valid = 1'b1;
    bus.touch_set   = 4'd7;
    bus.touch_way   = 2'd0;
    lookup("s7_same", 4'd7, 4'hF, exp_same);
    bus.touch_valid = 1'b0;
    lookup("s7_after", 4'd7, 4'hF, 2'd2);

    // Touch set 1 while looking up set 2: independent.
    bus.touch_valid = 1'b1;
    bus.touch_set   = 4'd1;
    bus.touch_way   = 2'd2;
    lookup("s2_par", 4'd2, 4'hF, 2'd0);
    bus.touch_valid = 1'b0;
    lookup("s2_again", 4'd2, 4'hF, 2'd0);
    lookup("s1_after", 4'd1, 4'hF, 2'd0);
    // Set 1 now 100: touching way0 keeps b2 -> 111 -> way3.
    touch(4'd1, 2'd0);
    lookup("s1_t0", 4'd1, 4'hF, 2'd3);

    // Reset the cycle after a lookup: pulse must not appear.
    bus.lookup_valid = 1'b1;
    bus.lookup_set   = 4'd4;
    bus.way_valid    = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("mid_rst_vld", {3'b0, bus.victim_valid}, 4'h0);
    chk("mid_rst_way", {2'b0, bus.victim_way}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", {3'b0, bus.victim_valid}, 4'h0);
    $display("reset mid-lookup -> valid=%0b", bus.victim_valid);

    // Every set back at tree 000.
    for (int s = 0; s < NUM_SETS; s++) begin
      lookup($sformatf("post_s%0d", s), s[3:0], 4'hF, 2'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
